// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider FSM states and default iteration count.
package cpu_defs;

  localparam int unsigned DivIterDefault = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_sign_adj.sv
// Conditional two's-complement negate; serves as abs() on operands and sign fix on results.
module div_sign_adj (
  input  logic        neg,
  input  logic [31:0] val,
  output logic [31:0] res
);

  always_comb begin
    res = neg ? (~val + 32'd1) : val;
  end

endmodule

// File: rtl/div_radix2.sv
// Iterative restoring divider, one quotient bit per cycle, with signed/unsigned modes.
module div_radix2
  import cpu_defs::*;
#(
  parameter int unsigned DIV_ITER = DivIterDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        sign,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        out_valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int unsigned CntW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_ITER - 1);

  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     dq_q, dq_d;
  logic [31:0]     div_q, div_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic [31:0] a_mag, b_mag, q_fix, r_fix;
  logic [32:0] shifted, diff;
  logic        step_ok;
  logic [31:0] step_rem, step_dq;

  div_sign_adj u_abs_a (.neg(sign & srca[31]), .val(srca),     .res(a_mag));
  div_sign_adj u_abs_b (.neg(sign & srcb[31]), .val(srcb),     .res(b_mag));
  div_sign_adj u_fix_q (.neg(qneg_q),          .val(step_dq),  .res(q_fix));
  div_sign_adj u_fix_r (.neg(rneg_q),          .val(step_rem), .res(r_fix));

  // dq_q holds the dividend shifting out at the top and the quotient shifting in at the bottom.
  // A set bit 32 in the shifted remainder already guarantees it exceeds the divisor.
  always_comb begin
    shifted  = {rem_q, dq_q[31]};
    diff     = shifted - {1'b0, div_q};
    step_ok  = shifted[32] | ~diff[32];
    step_rem = step_ok ? diff[31:0] : shifted[31:0];
    step_dq  = {dq_q[30:0], step_ok};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    div_d     = div_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dq_d    = a_mag;
          div_d   = b_mag;
          rem_d   = 32'd0;
          cnt_d   = '0;
          // Divide-by-zero keeps the all-ones quotient unnegated.
          qneg_d  = sign & (srca[31] ^ srcb[31]) & (|srcb);
          rneg_d  = sign & srca[31];
          state_d = StBusy;
        end
      end
      StBusy: begin
        busy = 1'b1;
        if (!in_valid) begin
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          dq_d  = step_dq;
          if (cnt_q == CntLast) begin
            hi_d    = r_fix;
            lo_d    = q_fix;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= 32'd0;
      dq_q    <= 32'd0;
      div_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_div_radix2.sv
// Randomized scoreboard bench for div_radix2 against an arithmetic reference model.
module tb_div_radix2;

  localparam int unsigned DivIter = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sign;
  logic [31:0] srca, srcb;
  logic        out_valid;
  logic [31:0] hi, lo;
  logic        busy;

  div_radix2 #(.DIV_ITER(DivIter)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .sign     (sign),
    .srca     (srca),
    .srcb     (srcb),
    .out_valid(out_valid),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned acc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;
  logic        prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: truncating division semantics, with divide-by-zero and overflow rules.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Monitor: every out_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        chk("single_cycle_pulse", {31'd0, prev_ov}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("lo", lo, e.lo);
          chk("hi", hi, e.hi);
          chk("latency", cyc - e.acc, DivIter + 1);
        end
      end
      prev_ov <= out_valid;
    end else begin
      prev_ov <= 1'b0;
    end
  end

  // Called at a negedge; DUT must be idle so the next posedge accepts.
  task automatic start(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_result);
    logic [63:0] r;
    chk("idle_before_accept", {31'd0, busy}, 32'd0);
    sign     = s;
    srca     = a;
    srcb     = b;
    in_valid = 1'b1;
    if (expect_result) begin
      r = model(s, a, b);
      exp_q.push_back('{hi: r[63:32], lo: r[31:0], acc: cyc});
      last_hi = r[63:32];
      last_lo = r[31:0];
    end
    @(posedge clk);
    #1;
    sign = 1'($urandom);
    srca = $urandom;
    srcb = $urandom;
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    bit seen = 1'b0;
    start(s, a, b, 1'b1);
    for (int i = 0; i < int'(DivIter) + 8 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) chk("timeout_out_valid", 32'd0, 32'd1);
  endtask

  task automatic idle_gap(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    rst = 1'b1;
    in_valid = 1'b0;
    sign = 1'b0;
    srca = 32'd0;
    srcb = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0;

    // Directed cases; the first accepts on the first edge after reset release.
    run_div(1'b0, 32'd100, 32'd7);
    idle_gap(1);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    idle_gap(1);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    idle_gap(2);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    idle_gap(1);
    run_div(1'b0, 32'h1234, 32'd0);
    idle_gap(1);
    run_div(1'b1, 32'hFFFF_FF00, 32'd0);
    idle_gap(1);

    // Back-to-back with in_valid held through DONE.
    run_div(1'b0, 32'd100, 32'd7);
    @(negedge clk);
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10);
    idle_gap(1);

    // Abort at BUSY cycle 10: no result, previous hi/lo retained.
    start(1'b0, 32'd5000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_hi", hi, last_hi);
    chk("abort_lo", lo, last_lo);
    repeat (DivIter + 5) @(negedge clk);
    run_div(1'b1, 32'hFFFF_FC18, 32'd13);
    idle_gap(1);

    // Reset at BUSY cycle 20: outputs clear at once, no later result.
    start(1'b0, 32'd999, 32'd10, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_gap(DivIter + 5);

    // Randomized mix, some back-to-back.
    for (int k = 0; k < 30; k++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(s, a, b);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      else idle_gap($urandom_range(1, 3));
    end
    idle_gap(4);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
